decoder_3_to_8: RTL and testbench

Registered 3-to-8 one-hot decoder with enable, used as the column-select driver for multiplexed LED arrays (e.g. the Conway-grid LED scanner). It converts a 3-bit column index into a one-hot select word, registered on the clock for glitch-free outputs. An optional compile-time blanking stage inserts one dark cycle on every column change to suppress LED ghosting.

---
 rtl/decoder_pkg.sv | 19 +
 rtl/decoder_3_to_8_core.sv | 12 +
 rtl/decoder_3_to_8.sv | 69 ++++++
 tb/tb_decoder_3_to_8.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared widths, the one-hot select type and the index-to-one-hot helper
// for the LED column-select decoder.
package decoder_pkg;

    localparam int IN_W  = 3;
    localparam int OUT_W = 8;

    typedef logic [OUT_W-1:0] onehot_t;

    function automatic onehot_t onehot(input logic [IN_W-1:0] idx);
        onehot_t oh;
        oh = '0;
        for (int i = 0; i < OUT_W; i++) begin
            oh[i] = (idx == IN_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/decoder_3_to_8_core.sv
// Combinational column index to one-hot select decode; every index is a
// legal code, so there is no out-of-range output.
module decoder_3_to_8_core
    import decoder_pkg::*;
(
    input  logic [IN_W-1:0] i_idx,
    output onehot_t         o_onehot
);

    assign o_onehot = onehot(i_idx);

endmodule

// File: rtl/decoder_3_to_8.sv
// Registered 3-to-8 column-select driver with enable and output polarity.
// Define DECODER_3_TO_8_BLANK_EN to insert one dark cycle on every column change.
module decoder_3_to_8
    import decoder_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [IN_W-1:0] in,
    output onehot_t         out,
    output logic [IN_W-1:0] sel_q,
    output logic            active
);

    localparam onehot_t POL_MASK = {OUT_W{ACTIVE_LOW}};

    onehot_t         w_dec;
    logic            w_blank;
    onehot_t         w_out_n;
    logic [IN_W-1:0] w_sel_n;
    logic            w_active_n;

    onehot_t         r_out;
    logic [IN_W-1:0] r_sel_q;
    logic            r_active;

    decoder_3_to_8_core u_core (
        .i_idx    (in),
        .o_onehot (w_dec)
    );

`ifdef DECODER_3_TO_8_BLANK_EN
    // Only a change while lit goes dark first; a decode after an idle cycle is immediate.
    assign w_blank = ena && r_active && (in != r_sel_q);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_out_n    = '0;
        w_sel_n    = r_sel_q;
        w_active_n = 1'b0;
        if (ena && !w_blank) begin
            w_out_n    = w_dec;
            w_sel_n    = in;
            w_active_n = 1'b1;
        end
    end

    // Polarity is folded in ahead of the register so the pins come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out    <= POL_MASK;
            r_sel_q  <= '0;
            r_active <= 1'b0;
        end else begin
            r_out    <= w_out_n ^ POL_MASK;
            r_sel_q  <= w_sel_n;
            r_active <= w_active_n;
        end
    end

    assign out    = r_out;
    assign sel_q  = r_sel_q;
    assign active = r_active;

endmodule

// File: tb/tb_decoder_3_to_8.sv
// Directed bench for decoder_3_to_8: both output polarities side by side,
// expectations follow whether DECODER_3_TO_8_BLANK_EN is defined.
module tb_decoder_3_to_8;
    import decoder_pkg::*;

    logic            clk;
    logic            clk_en;
    logic            rst;
    logic            ena;
    logic [IN_W-1:0] in;
    onehot_t         out_h, out_l;
    logic [IN_W-1:0] sel_h, sel_l;
    logic            act_h, act_l;

    int checks = 0;
    int errors = 0;

    decoder_3_to_8 #(.ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst), .ena(ena), .in(in),
        .out(out_h), .sel_q(sel_h), .active(act_h)
    );

    decoder_3_to_8 #(.ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .ena(ena), .in(in),
        .out(out_l), .sel_q(sel_l), .active(act_l)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic       ena;
        logic [2:0] in;
        logic [7:0] exp_out;
        logic [2:0] exp_sel;
        logic       exp_act;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compares both instances against one active-high expectation.
    task automatic chk_all(input string name, input logic [7:0] e_out,
                           input logic [2:0] e_sel, input logic e_act);
        chk({name, " out_h"}, out_h, e_out);
        chk({name, " out_l"}, out_l, ~e_out);
        chk({name, " sel_h"}, {5'b0, sel_h}, {5'b0, e_sel});
        chk({name, " sel_l"}, {5'b0, sel_l}, {5'b0, e_sel});
        chk({name, " act_h"}, {7'b0, act_h}, {7'b0, e_act});
        chk({name, " act_l"}, {7'b0, act_l}, {7'b0, e_act});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef DECODER_3_TO_8_BLANK_EN
        vecs[0]  = '{1'b1, 3'd0, 8'h01, 3'd0, 1'b1};
        vecs[1]  = '{1'b1, 3'd1, 8'h00, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 8'h04, 3'd2, 1'b1};
        vecs[3]  = '{1'b1, 3'd3, 8'h00, 3'd2, 1'b0};
        vecs[4]  = '{1'b1, 3'd4, 8'h10, 3'd4, 1'b1};
        vecs[5]  = '{1'b1, 3'd5, 8'h00, 3'd4, 1'b0};
        vecs[6]  = '{1'b1, 3'd6, 8'h40, 3'd6, 1'b1};
        vecs[7]  = '{1'b1, 3'd7, 8'h00, 3'd6, 1'b0};
        vecs[8]  = '{1'b0, 3'd3, 8'h00, 3'd6, 1'b0};
`else
        vecs[0]  = '{1'b1, 3'd0, 8'h01, 3'd0, 1'b1};
        vecs[1]  = '{1'b1, 3'd1, 8'h02, 3'd1, 1'b1};
        vecs[2]  = '{1'b1, 3'd2, 8'h04, 3'd2, 1'b1};
        vecs[3]  = '{1'b1, 3'd3, 8'h08, 3'd3, 1'b1};
        vecs[4]  = '{1'b1, 3'd4, 8'h10, 3'd4, 1'b1};
        vecs[5]  = '{1'b1, 3'd5, 8'h20, 3'd5, 1'b1};
        vecs[6]  = '{1'b1, 3'd6, 8'h40, 3'd6, 1'b1};
        vecs[7]  = '{1'b1, 3'd7, 8'h80, 3'd7, 1'b1};
        vecs[8]  = '{1'b0, 3'd3, 8'h00, 3'd7, 1'b0};
`endif
        // Enable rising after an idle cycle decodes immediately, then holds steady.
        vecs[9]  = '{1'b1, 3'd3, 8'h08, 3'd3, 1'b1};
        vecs[10] = '{1'b1, 3'd3, 8'h08, 3'd3, 1'b1};

        // Reset with the clock stopped: outputs must clear without any edge.
        clk_en = 1'b0;
        rst    = 1'b0;
        ena    = 1'b1;
        in     = 3'd5;
        #2;
        rst = 1'b1;
        #3;
        chk_all("reset", 8'h00, 3'd0, 1'b0);
        #10;
        rst    = 1'b0;
        clk_en = 1'b1;
        #2;

        for (int i = 0; i < 11; i++) begin
            ena = vecs[i].ena;
            in  = vecs[i].in;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_sel, vecs[i].exp_act);
        end

        // Column change while lit: dark cycle first when blanking is built in.
        ena = 1'b1;
        in  = 3'd2;
        begin
            int n = 0;
            step();
            while (out_h !== 8'h04 && n < 4) begin
                step();
                n++;
            end
            chk("blank settle", out_h, 8'h04);
        end
        in = 3'd6;
        step();
`ifdef DECODER_3_TO_8_BLANK_EN
        chk_all("blank gap", 8'h00, 3'd2, 1'b0);
        step();
`endif
        chk_all("blank next", 8'h40, 3'd6, 1'b1);

        // Reset pulsed between edges mid-operation, then recovery.
        in = 3'd4;
        step();
`ifdef DECODER_3_TO_8_BLANK_EN
        step();
`endif
        chk_all("pre midrst", 8'h10, 3'd4, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("midrst", 8'h00, 3'd0, 1'b0);
        #1;
        rst = 1'b0;
        step();
        chk_all("post midrst", 8'h10, 3'd4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
